// File: rtl/fir_frame_sequencer_if.sv
// fir_frame_sequencer_if: sample input stream and filtered output stream
interface fir_frame_sequencer_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid, out_last);
  modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid, out_last);
endinterface

// File: rtl/fir_frame_sequencer.sv
// fir_frame_sequencer: assembles a sample frame, kicks the frame filter and streams its result out
module fir_frame_sequencer #(
  parameter int FRAME_LEN = 256,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  fir_frame_sequencer_if.slave               bus,
  output logic [FRAME_LEN-1:0][DATA_W-1:0]   o_frame_in,
  output logic                               o_start_flg,
  input  logic                               i_filt_rdy,
  input  logic [FRAME_LEN-1:0][DATA_W-1:0]   i_frame_out,
  output logic                               o_busy,
  output logic                               o_timeout_err
);
  localparam int AW = $clog2(FRAME_LEN);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {FILL, START, WAIT, DRAIN} state_t;
  state_t                           r_state;
  logic [AW-1:0]                    r_wr_cnt;
  logic [AW-1:0]                    r_rd_cnt;
  logic [TW-1:0]                    r_wait_cnt;
  logic                             r_in_ready;
  logic                             r_start_flg;
  logic                             r_out_valid;
  logic                             r_out_last;
  logic                             r_busy;
  logic                             r_timeout_err;
  logic [FRAME_LEN-1:0][DATA_W-1:0] r_frame_in;
  logic                             w_in_hs;
  logic                             w_out_hs;
  assign w_in_hs       = bus.in_valid & r_in_ready;
  assign w_out_hs      = r_out_valid & bus.out_ready;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_data  = i_frame_out[r_rd_cnt];
  assign o_frame_in    = r_frame_in;
  assign o_start_flg   = r_start_flg;
  assign o_busy        = r_busy;
  assign o_timeout_err = r_timeout_err;
  // Frame FSM: outputs are registered alongside every state change so they are pure Moore decodes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= FILL;
      r_wr_cnt      <= '0;
      r_rd_cnt      <= '0;
      r_wait_cnt    <= '0;
      r_in_ready    <= 1'b1;
      r_start_flg   <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_in    <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_in_hs) begin
            r_frame_in[r_wr_cnt] <= bus.in_data;
            r_wr_cnt             <= r_wr_cnt + 1'b1;
            if (r_wr_cnt == AW'(FRAME_LEN - 1)) begin
              r_wr_cnt    <= '0;
              r_state     <= START;
              r_in_ready  <= 1'b0;
              r_start_flg <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
        end
        START: begin
          r_state     <= WAIT;
          r_start_flg <= 1'b0;
          r_wait_cnt  <= '0;
        end
        WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          // wait_cnt==0 masks a ready level left over from the previous frame
          if (r_wait_cnt != '0 && i_filt_rdy) begin
            r_state     <= DRAIN;
            r_rd_cnt    <= '0;
            r_out_valid <= 1'b1;
            r_out_last  <= (FRAME_LEN == 1);
          end else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
            r_state       <= FILL;
            r_timeout_err <= 1'b1;
            r_in_ready    <= 1'b1;
            r_busy        <= 1'b0;
          end
        end
        DRAIN: begin
          if (w_out_hs) begin
            r_rd_cnt   <= r_rd_cnt + 1'b1;
            r_out_last <= (r_rd_cnt == AW'(FRAME_LEN - 2));
            if (r_out_last) begin
              r_state     <= FILL;
              r_rd_cnt    <= '0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_frame_sequencer.sv
// tb_fir_frame_sequencer: scoreboard bench with a behavioural two-tap averaging filter
module tb_fir_frame_sequencer;
  localparam int N  = 256;
  localparam int W  = 8;
  localparam int TO = 1024;
  typedef logic [N-1:0][W-1:0] frame_t;
  typedef struct { int pat; bit gaps; bit stalls; bit hold; int lat; int exp_lat; } vec_t;
  typedef struct { logic [W-1:0] d; logic l; } exp_t;
  logic   clk = 0;
  logic   rst = 0;
  logic   filt_rdy;
  logic   start_flg;
  logic   busy;
  logic   terr;
  frame_t frame_in;
  frame_t frame_out;
  frame_t exp_frame;
  fir_frame_sequencer_if #(.DATA_W(W)) bus ();
  fir_frame_sequencer #(.FRAME_LEN(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .o_frame_in(frame_in), .o_start_flg(start_flg),
    .i_filt_rdy(filt_rdy), .i_frame_out(frame_out), .o_busy(busy), .o_timeout_err(terr));
  always #5 clk = ~clk;
  int errs = 0, chks = 0, cyc = 0;
  exp_t q[$];
  int frames_done = 0, pops = 0, starts = 0, start_cyc = 0, hs_edge = 0, fv_cyc = 0, err_cyc = -1, vcount = 0;
  bit was_valid = 0, prev_stall = 0, prev_err = 0, stall_en = 0;
  logic [W-1:0] prev_d;
  logic prev_l;
  int filt_mode = 0, filt_lat = 0;
  logic [W-1:0] smp[N];
  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic frame_t filt(input frame_t x);
    frame_t y;
    logic [W:0] s;
    logic [W-1:0] p = '0;
    for (int i = 0; i < N; i++) begin
      s = {1'b0, x[i]} + {1'b0, p};
      y[i] = s[W:1];
      p = x[i];
    end
    return y;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      was_valid = 0;
      prev_stall = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) hs_edge = cyc + 1;
      chk("in_ready_vs_busy", bus.in_ready, !busy);
      if (start_flg) begin starts++; start_cyc = cyc; end
      if (bus.out_valid && !was_valid) fv_cyc = cyc;
      if (bus.out_valid) vcount++;
      was_valid = bus.out_valid;
      if (prev_stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, prev_d);
        chk("stall_last", bus.out_last, prev_l);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_d = bus.out_data;
      prev_l = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chks++; errs++;
          $display("FAIL unexpected_output: got data %0d with empty scoreboard", bus.out_data);
        end else begin
          e = q.pop_front();
          chk("out_data", bus.out_data, e.d);
          chk("out_last", bus.out_last, e.l);
          pops++;
          if (e.l) frames_done++;
        end
      end
    end
    if (terr && !prev_err) err_cyc = cyc;
    prev_err = terr;
  end

  initial begin
    int n;
    n = 0;
    bus.out_ready = 1;
    forever begin
      @(posedge clk); #1;
      if (stall_en && n == 0 && $urandom_range(0, 5) == 0) n = $urandom_range(1, 10);
      bus.out_ready = (n == 0);
      if (n > 0) n--;
    end
  end

  initial begin
    bit s;
    int fcnt;
    fcnt = 0;
    filt_rdy = 1;
    for (int i = 0; i < N; i++) frame_out[i] = W'(i * 3 + 1);
    forever begin
      @(negedge clk); s = start_flg;
      @(posedge clk); #1;
      if (s) begin
        frame_out = filt(frame_in);
        if (filt_mode != 0) begin filt_rdy = 0; fcnt = 1; end
      end else if (filt_mode == 1 && !filt_rdy) begin
        if (fcnt == filt_lat) filt_rdy = 1;
        fcnt++;
      end
      if (filt_mode == 0) filt_rdy = 1;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_start_flg"}, start_flg, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout_err"}, terr, 0);
    chk({tag, "_frame_in_zero"}, frame_in == '0, 1);
    chk({tag, "_out_data"}, bus.out_data, frame_out[0]);
  endtask

  task automatic send_frame(input int pat, input bit gaps);
    for (int i = 0; i < N; i++) begin
      bit hs;
      smp[i] = pat == 0 ? W'(i) : pat == 1 ? W'($urandom) : pat == 2 ? 8'hFF : (i % 2 == 1 ? 8'hFF : 8'h00);
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      bus.in_data = smp[i];
      bus.in_valid = 1;
      hs = 0;
      for (int t = 0; t < 20 && !hs; t++) begin
        @(negedge clk); hs = bus.in_ready;
        @(posedge clk); #1;
      end
      chk("in_handshake", hs, 1);
    end
    bus.in_valid = 0;
  endtask

  task automatic push_expected();
    frame_t y;
    exp_t e;
    for (int i = 0; i < N; i++) exp_frame[i] = smp[i];
    y = filt(exp_frame);
    for (int i = 0; i < N; i++) begin
      e.d = y[i];
      e.l = (i == N - 1);
      q.push_back(e);
    end
  endtask

  task automatic wait_frames(input int target);
    for (int t = 0; t < 5000 && frames_done < target; t++) @(posedge clk);
    #1;
    chk("drain_done", frames_done, target);
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    filt_mode = v.lat == 0 ? 0 : 1;
    filt_lat = v.lat;
    stall_en = v.stalls;
    starts = 0;
    base = frames_done;
    send_frame(v.pat, v.gaps);
    if (v.hold) begin bus.in_valid = 1; bus.in_data = 8'h5A; end
    push_expected();
    wait_frames(base + 1);
    bus.in_valid = 0;
    stall_en = 0;
    chk("start_pulses", starts, 1);
    chk("start_offset", start_cyc - hs_edge, 0);
    chk("first_valid_latency", fv_cyc - hs_edge, v.exp_lat);
    chk("frame_in_contents", frame_in == exp_frame, 1);
    chk("queue_empty", q.size(), 0);
  endtask

  initial begin
    int base, vbase;
    tbl[0] = '{0, 0, 0, 0, 0, 3};
    tbl[1] = '{1, 1, 1, 0, 5, 7};
    tbl[2] = '{2, 0, 0, 1, 1, 3};
    tbl[3] = '{3, 0, 1, 0, 0, 3};
    bus.in_valid = 0;
    bus.in_data = 0;
    #1 rst = 1;
    #2 check_reset("init");
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_reset_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) run_vec(tbl[k]);
    filt_mode = 2;
    starts = 0;
    vbase = vcount;
    base = pops;
    send_frame(1, 0);
    for (int t = 0; t < 2000 && !terr; t++) @(posedge clk);
    @(negedge clk);
    chk("timeout_err_set", terr, 1);
    chk("timeout_cycle", err_cyc - hs_edge, TO + 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_in_ready", bus.in_ready, 1);
    chk("timeout_no_valid", vcount - vbase, 0);
    chk("timeout_no_pops", pops - base, 0);
    @(posedge clk); #1;
    run_vec('{1, 0, 0, 0, 2, 4});
    chk("timeout_err_sticky", terr, 1);
    filt_mode = 0;
    base = pops;
    send_frame(0, 0);
    push_expected();
    for (int t = 0; t < 2000 && pops < base + 100; t++) @(posedge clk);
    #3 rst = 1;
    #1 check_reset("drain_rst");
    q.delete();
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    run_vec('{3, 0, 0, 0, 0, 3});
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
